i2c_slave_regs: RTL and testbench

I2C target that terminates the bus driven by the team's I2C master and exposes a 16 x 8-bit register file. It oversamples SCL/SDA on the system clock, detects START/STOP, matches a fixed 7-bit address, and ACKs. Write transactions load a register pointer and then write data; read transactions return data from the pointer. It is the bench and FPGA-side partner of the master and shares its `clk`/`rst` domain.

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_bus_sync.sv | 51 +++++
 rtl/i2c_slave_regs.sv | 208 ++++++++++++++++++++
 tb/tb_i2c_slave_regs.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: state encoding, ACK/NACK bus levels and default target address.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8,
    ST_WAIT_STOP = 4'd9
  } i2c_state_e;

  localparam logic       ACK                = 1'b0;
  localparam logic       NACK               = 1'b1;
  localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h50;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchroniser with one-cycle edge-detect delay; flags scl edges and START/STOP.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_dly_q, scl_dly_d;
  logic                   sda_dly_q, sda_dly_d;
  logic                   scl_s;

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda};
    scl_s      = scl_sync_q[SYNC_STAGES-1];
    sda_s      = sda_sync_q[SYNC_STAGES-1];
    scl_dly_d  = scl_s;
    sda_dly_d  = sda_s;
    scl_rise   = scl_s & ~scl_dly_q;
    scl_fall   = ~scl_s & scl_dly_q;
    // SCL must be high on both sides of the SDA transition.
    start_det  = scl_s & scl_dly_q & sda_dly_q & ~sda_s;
    stop_det   = scl_s & scl_dly_q & ~sda_dly_q & sda_s;
  end

  // Idle bus level is high, so reset to 1 to avoid phantom events.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_dly_q  <= 1'b1;
      sda_dly_q  <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_dly_q  <= scl_dly_d;
      sda_dly_q  <= sda_dly_d;
    end
  end

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target exposing a 2**REG_AW x 8-bit register file behind a register pointer.
// Define I2C_SLAVE_AUTOINC_EN to advance the pointer after each data byte.
module i2c_slave_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = DEFAULT_SLAVE_ADDR,
  parameter int         REG_AW      = 4,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl,
  inout  wire               sda,
  output logic              wr_strobe,
  output logic [REG_AW-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              addr_match,
  output logic              busy
);

  localparam int NREGS = 2**REG_AW;
`ifdef I2C_SLAVE_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda       (sda),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_state_e        state_q, state_d;
  logic              phase_q, phase_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              rw_q, rw_d;
  logic [REG_AW-1:0] ptr_q, ptr_d;
  logic [7:0]        regs_q [NREGS];
  logic [7:0]        regs_d [NREGS];
  logic              sda_oe_q, sda_oe_d;
  logic              wr_strobe_q, wr_strobe_d;
  logic [REG_AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              addr_match_q, addr_match_d;
  logic              busy_q, busy_d;
  logic [7:0]        rx_byte;
  logic              last_bit;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    rw_d         = rw_q;
    ptr_d        = ptr_q;
    regs_d       = regs_q;
    sda_oe_d     = sda_oe_q;
    wr_strobe_d  = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    addr_match_d = addr_match_q;
    busy_d       = busy_q;
    rx_byte      = {shift_q[6:0], sda_s};
    last_bit     = (bit_cnt_q == 3'd0);

    if (start_det) begin
      state_d      = ST_ADDR;
      phase_d      = 1'b0;
      bit_cnt_d    = 3'd7;
      addr_match_d = 1'b0;
      sda_oe_d     = 1'b0;
      busy_d       = 1'b1;
    end else if (stop_det) begin
      state_d      = ST_IDLE;
      phase_d      = 1'b0;
      addr_match_d = 1'b0;
      sda_oe_d     = 1'b0;
      busy_d       = 1'b0;
    end else begin
      unique case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA: if (scl_rise) begin
          shift_d   = rx_byte;
          bit_cnt_d = bit_cnt_q - 3'd1;
          if (last_bit) begin
            phase_d = 1'b0;
            if (state_q == ST_ADDR) begin
              if (rx_byte[7:1] == SLAVE_ADDR) begin
                state_d      = ST_ADDR_ACK;
                rw_d         = rx_byte[0];
                addr_match_d = 1'b1;
              end else begin
                state_d = ST_WAIT_STOP;
              end
            end else if (state_q == ST_PTR) begin
              state_d = ST_PTR_ACK;
              ptr_d   = rx_byte[REG_AW-1:0];
            end else begin
              state_d        = ST_WDATA_ACK;
              regs_d[ptr_q]  = rx_byte;
              wr_strobe_d    = 1'b1;
              wr_addr_d      = ptr_q;
              wr_data_d      = rx_byte;
            end
          end
        end
        // Phase 0 waits for the fall that starts the ACK, phase 1 for the one that ends it.
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
          if (!phase_q) begin
            sda_oe_d = 1'b1;
            phase_d  = 1'b1;
          end else begin
            phase_d   = 1'b0;
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd7;
            if (state_q == ST_ADDR_ACK && rw_q) begin
              state_d  = ST_RDATA;
              shift_d  = regs_q[ptr_q];
              sda_oe_d = (regs_q[ptr_q][7] == 1'b0);
            end else if (state_q == ST_ADDR_ACK) begin
              state_d = ST_PTR;
            end else begin
              state_d = ST_WDATA;
              if (state_q == ST_WDATA_ACK && AUTOINC) ptr_d = ptr_q + REG_AW'(1);
            end
          end
        end
        ST_RDATA: if (scl_fall) begin
          if (last_bit) begin
            sda_oe_d = 1'b0;
            phase_d  = 1'b0;
            state_d  = ST_RDATA_ACK;
          end else begin
            shift_d   = {shift_q[6:0], shift_q[7]};
            sda_oe_d  = (shift_q[6] == 1'b0);
            bit_cnt_d = bit_cnt_q - 3'd1;
          end
        end
        ST_RDATA_ACK: begin
          if (!phase_q && scl_rise) begin
            if (sda_s == NACK) begin
              state_d = ST_WAIT_STOP;
            end else begin
              phase_d = 1'b1;
              if (AUTOINC) ptr_d = ptr_q + REG_AW'(1);
            end
          end else if (phase_q && scl_fall) begin
            phase_d   = 1'b0;
            state_d   = ST_RDATA;
            bit_cnt_d = 3'd7;
            shift_d   = regs_q[ptr_q];
            sda_oe_d  = (regs_q[ptr_q][7] == 1'b0);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      phase_q      <= 1'b0;
      bit_cnt_q    <= 3'd7;
      shift_q      <= '0;
      rw_q         <= 1'b0;
      ptr_q        <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      sda_oe_q     <= 1'b0;
      wr_strobe_q  <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      addr_match_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      rw_q         <= rw_d;
      ptr_q        <= ptr_d;
      regs_q       <= regs_d;
      sda_oe_q     <= sda_oe_d;
      wr_strobe_q  <= wr_strobe_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      addr_match_q <= addr_match_d;
      busy_q       <= busy_d;
    end
  end

  assign sda        = sda_oe_q ? 1'b0 : 1'bz;
  assign wr_strobe  = wr_strobe_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign addr_match = addr_match_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: bit-banged I2C master, register-file reference model, strobe scoreboard.
module tb_i2c_slave_regs;
  import i2c_pkg::*;

  localparam int         Q  = 5;
  localparam logic [6:0] SA = 7'h50;
`ifdef I2C_SLAVE_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  // ---------------- clock / reset / bus ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       m_oe;
  wire        sda;
  logic       wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       addr_match;
  logic       busy;

  always #5 clk = ~clk;
  assign sda = m_oe ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave_regs dut (
    .clk        (clk),
    .rst        (rst),
    .scl        (scl),
    .sda        (sda),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .addr_match (addr_match),
    .busy       (busy)
  );

  // ---------------- scoreboard / model state ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [11:0] exp_q[$];
  logic [11:0] obs_q[$];
  logic [7:0]  model_regs [16];
  int          model_ptr;
  logic [7:0]  tx_buf [4];
  logic [7:0]  rx_buf [4];
  logic [7:0]  exp_rd [4];
  logic        busy_seen, match_seen;

  always @(negedge clk) begin
    if (busy === 1'b1) busy_seen = 1'b1;
    if (addr_match === 1'b1) match_seen = 1'b1;
    if (rst === 1'b0 && wr_strobe === 1'b1) obs_q.push_back({wr_addr, wr_data});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic void mdl_reset();
    for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
    model_ptr = 0;
  endfunction

  function automatic void mdl_write(input logic [6:0] a, input logic [7:0] p, input int n);
    if (a != SA) return;
    model_ptr = int'(p) % 16;
    for (int i = 0; i < n; i++) begin
      model_regs[model_ptr] = tx_buf[i];
      exp_q.push_back({4'(model_ptr), tx_buf[i]});
      if (AUTOINC) model_ptr = (model_ptr + 1) % 16;
    end
  endfunction

  function automatic void mdl_read(input logic [6:0] a, input int n);
    for (int i = 0; i < n; i++) begin
      if (a != SA) begin
        exp_rd[i] = 8'hFF;
      end else begin
        exp_rd[i] = model_regs[model_ptr];
        if (AUTOINC && i < n - 1) model_ptr = (model_ptr + 1) % 16;
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_bit_out(input logic b);
    clks(Q); m_oe = ~b;
    clks(Q); scl = 1'b1;
    clks(2 * Q); scl = 1'b0;
  endtask

  task automatic bus_bit_in(output logic b);
    clks(Q); m_oe = 1'b0;
    clks(Q); scl = 1'b1;
    clks(Q); b = sda;
    clks(Q); scl = 1'b0;
  endtask

  task automatic bus_start();
    if (scl === 1'b1) begin
      clks(Q);
    end else begin
      clks(Q); m_oe = 1'b0;
      clks(Q); scl = 1'b1;
      clks(Q);
    end
    m_oe = 1'b1;
    clks(Q); scl = 1'b0;
  endtask

  task automatic bus_stop();
    clks(Q); m_oe = 1'b1;
    clks(Q); scl = 1'b1;
    clks(Q); m_oe = 1'b0;
    clks(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) bus_bit_out(b[i]);
    bus_bit_in(ack);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] b);
    logic bit_v;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bus_bit_in(bit_v);
      b = {b[6:0], bit_v};
    end
    bus_bit_out(mack);
  endtask

  task automatic drv_write(input logic [6:0] a, input logic [7:0] p, input int n,
                           output logic [5:0] acks);
    logic ack;
    acks = '0;
    bus_start();
    send_byte({a, 1'b0}, ack); acks[0] = ack;
    send_byte(p, ack);         acks[1] = ack;
    for (int i = 0; i < n; i++) begin
      send_byte(tx_buf[i], ack);
      acks[i + 2] = ack;
    end
  endtask

  task automatic drv_read(input logic [6:0] a, input int n, output logic aack);
    logic [7:0] b;
    bus_start();
    send_byte({a, 1'b1}, aack);
    for (int i = 0; i < n; i++) begin
      recv_byte((i == n - 1) ? NACK : ACK, b);
      rx_buf[i] = b;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; scl = 1'b1; m_oe = 1'b0;
    clks(4);
    rst = 1'b0;
    clks(3);
    n_cmp++; if (sda !== 1'b1) begin n_err++; $display("FAIL reset_sda: got %b want 1", sda); end
    n_cmp++; if (wr_strobe !== 1'b0) begin n_err++; $display("FAIL reset_wr_strobe: got %b want 0", wr_strobe); end
    n_cmp++; if (wr_addr !== 4'h0) begin n_err++; $display("FAIL reset_wr_addr: got %h want 0", wr_addr); end
    n_cmp++; if (wr_data !== 8'h00) begin n_err++; $display("FAIL reset_wr_data: got %h want 00", wr_data); end
    n_cmp++; if (addr_match !== 1'b0) begin n_err++; $display("FAIL reset_addr_match: got %b want 0", addr_match); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_single_write();
    logic [5:0] acks;
    busy_seen = 1'b0; match_seen = 1'b0;
    tx_buf[0] = 8'h5A;
    mdl_write(SA, 8'h03, 1);
    drv_write(SA, 8'h03, 1, acks);
    bus_stop();
    clks(4);
    n_cmp++; if (acks !== 6'b000000) begin n_err++; $display("FAIL single_acks: got %b want 000000", acks); end
    n_cmp++; if (busy_seen !== 1'b1) begin n_err++; $display("FAIL single_busy_seen: got %b want 1", busy_seen); end
    n_cmp++; if (match_seen !== 1'b1) begin n_err++; $display("FAIL single_match_seen: got %b want 1", match_seen); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_after_stop: got %b want 0", busy); end
    n_cmp++; if (addr_match !== 1'b0) begin n_err++; $display("FAIL single_match_after_stop: got %b want 0", addr_match); end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL single_strobe_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL single_strobe[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_wrap();
    logic [5:0] acks;
    logic       aack;
    tx_buf[0] = 8'h11; tx_buf[1] = 8'h22;
    mdl_write(SA, 8'h0F, 2);
    drv_write(SA, 8'h0F, 2, acks);
    bus_stop();
    n_cmp++; if (acks !== 6'b000000) begin n_err++; $display("FAIL wrap_acks: got %b want 000000", acks); end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL wrap_strobe_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL wrap_strobe[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
    mdl_write(SA, 8'h0F, 0);
    drv_write(SA, 8'h0F, 0, acks);
    mdl_read(SA, 2);
    drv_read(SA, 2, aack);
    bus_stop();
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (rx_buf[i] !== exp_rd[i]) begin n_err++; $display("FAIL wrap_readback[%0d]: got %h want %h", i, rx_buf[i], exp_rd[i]); end
    end
  endtask

  task automatic test_repeated_start_read();
    logic [5:0] acks;
    logic       aack;
    mdl_write(SA, 8'h03, 0);
    drv_write(SA, 8'h03, 0, acks);
    mdl_read(SA, 2);
    drv_read(SA, 2, aack);
    clks(Q);
    n_cmp++; if (sda !== 1'b1) begin n_err++; $display("FAIL rd_release_after_nack: got %b want 1", sda); end
    bus_stop();
    n_cmp++; if (aack !== ACK) begin n_err++; $display("FAIL rd_addr_ack: got %b want %b", aack, ACK); end
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (rx_buf[i] !== exp_rd[i]) begin n_err++; $display("FAIL rd_data[%0d]: got %h want %h", i, rx_buf[i], exp_rd[i]); end
    end
  endtask

  task automatic test_bad_addr();
    logic [5:0] acks;
    match_seen = 1'b0;
    tx_buf[0] = 8'h77;
    mdl_write(7'h51, 8'h03, 1);
    drv_write(7'h51, 8'h03, 1, acks);
    bus_stop();
    n_cmp++; if (acks !== 6'b000111) begin n_err++; $display("FAIL bad_addr_acks: got %b want 000111", acks); end
    n_cmp++; if (match_seen !== 1'b0) begin n_err++; $display("FAIL bad_addr_match: got %b want 0", match_seen); end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL bad_addr_strobe_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    logic       ack;
    logic [5:0] acks;
    logic       aack;
    bus_start();
    send_byte({SA, 1'b0}, ack);
    send_byte(8'h05, ack);
    tx_buf[0] = 8'h33;
    mdl_write(SA, 8'h05, 1);
    for (int i = 7; i >= 0; i--) bus_bit_out(tx_buf[0][i]);
    clks(Q); m_oe = 1'b0;
    clks(Q); scl = 1'b1;
    clks(Q);
    n_cmp++; if (sda !== 1'b0) begin n_err++; $display("FAIL rstmid_ack_driven: got %b want 0", sda); end
    rst = 1'b1;
    clks(1);
    n_cmp++; if (sda !== 1'b1) begin n_err++; $display("FAIL rstmid_sda_release: got %b want 1", sda); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    clks(2);
    rst = 1'b0;
    mdl_reset();
    clks(Q); scl = 1'b0;
    for (int i = 0; i < 5; i++) bus_bit_out(1'($urandom_range(0, 1)));
    bus_stop();
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL rstmid_strobe_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rstmid_strobe[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
    mdl_write(SA, 8'h05, 0);
    drv_write(SA, 8'h05, 0, acks);
    mdl_read(SA, 2);
    drv_read(SA, 2, aack);
    bus_stop();
    n_cmp++; if (acks !== 6'b000000) begin n_err++; $display("FAIL rstmid_next_acks: got %b want 000000", acks); end
    n_cmp++; if (aack !== ACK) begin n_err++; $display("FAIL rstmid_next_rd_ack: got %b want %b", aack, ACK); end
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (rx_buf[i] !== exp_rd[i]) begin n_err++; $display("FAIL rstmid_regs_cleared[%0d]: got %h want %h", i, rx_buf[i], exp_rd[i]); end
    end
  endtask

  task automatic test_random();
    logic [5:0] acks, exp_a;
    logic       aack;
    logic [6:0] a;
    logic [7:0] p;
    int         n;
    for (int it = 0; it < 14; it++) begin
      a = ($urandom_range(0, 4) == 0) ? 7'h51 : SA;
      p = 8'($urandom_range(0, 255));
      n = $urandom_range(1, 3);
      if ($urandom_range(0, 2) != 0) begin
        for (int i = 0; i < n; i++) tx_buf[i] = 8'($urandom_range(0, 255));
        exp_a = '0;
        for (int i = 0; i < n + 2; i++) exp_a[i] = (a == SA) ? ACK : NACK;
        mdl_write(a, p, n);
        drv_write(a, p, n, acks);
        bus_stop();
        n_cmp++; if (acks !== exp_a) begin n_err++; $display("FAIL rand_wr_acks it%0d: got %b want %b", it, acks, exp_a); end
      end else begin
        mdl_write(a, p, 0);
        drv_write(a, p, 0, acks);
        mdl_read(a, n);
        drv_read(a, n, aack);
        bus_stop();
        n_cmp++;
        if (aack !== ((a == SA) ? ACK : NACK)) begin n_err++; $display("FAIL rand_rd_ack it%0d: got %b want %b", it, aack, (a == SA) ? ACK : NACK); end
        for (int i = 0; i < n; i++) begin
          n_cmp++;
          if (rx_buf[i] !== exp_rd[i]) begin n_err++; $display("FAIL rand_rd_data it%0d[%0d]: got %h want %h", it, i, rx_buf[i], exp_rd[i]); end
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL rand_strobe_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand_strobe[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; scl = 1'b1; m_oe = 1'b0;
    busy_seen = 1'b0; match_seen = 1'b0;
    mdl_reset();
    test_reset();
    test_single_write();
    test_wrap();
    test_repeated_start_read();
    test_bad_addr();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
